// File: rtl/nibble_serial_adder_8_bit_pkg.sv
// Shared types and default sizing for the nibble-serial adder.
// The top reuses one narrow adder slice over several clock cycles.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int WIDTH_DEF   = 8;
    localparam int SLICE_W_DEF = 4;

endpackage

// File: rtl/nibble_serial_adder_8_bit_slice.sv
// Combinational ripple-carry adder slice.
// The top instantiates it once and feeds it one operand nibble per cycle.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[W];
    end

endmodule

// File: rtl/nibble_serial_adder_8_bit.sv
// Multi-cycle adder: accepts operands by valid/ready, adds them one slice per
// cycle through a shared adder slice, and returns sum/cout by valid/ready.
module nibble_serial_adder_8_bit
    import adder_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS  = WIDTH / SLICE_W;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [WIDTH-1:0]    opA;
    logic [WIDTH-1:0]    opB;
    logic [WIDTH-1:0]    work;
    logic [WIDTH-1:0]    workNext;
    logic                carry;
    logic [WIDTH-1:0]    sumReg;
    logic                coutReg;
    logic                validReg;

    logic [SLICE_W-1:0]  sliceA;
    logic [SLICE_W-1:0]  sliceB;
    logic [SLICE_W-1:0]  sliceS;
    logic                sliceCo;

    // Select the current slice of the latched operands and merge the slice
    // result into the work register image for this step.
    always_comb begin
        sliceA   = opA[step*SLICE_W +: SLICE_W];
        sliceB   = opB[step*SLICE_W +: SLICE_W];
        workNext = work;
        workNext[step*SLICE_W +: SLICE_W] = sliceS;
    end

    adder_slice #(
        .W (SLICE_W)
    ) u_slice (
        .a  (sliceA),
        .b  (sliceB),
        .ci (carry),
        .s  (sliceS),
        .co (sliceCo)
    );

    // Output regs stay zero until the final step, so partial sums never leak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            opA      <= '0;
            opB      <= '0;
            work     <= '0;
            carry    <= 1'b0;
            sumReg   <= '0;
            coutReg  <= 1'b0;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opA   <= x;
                        opB   <= y;
                        carry <= cin;
                        step  <= '0;
                        work  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    work  <= workNext;
                    carry <= sliceCo;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        sumReg   <= workNext;
                        coutReg  <= sliceCo;
                        validReg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sumReg   <= '0;
                        coutReg  <= 1'b0;
                        validReg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = validReg;
    assign sum       = sumReg;
    assign cout      = coutReg;

endmodule

// File: tb/tb_nibble_serial_adder_8_bit.sv
// Bench for nibble_serial_adder_8_bit: directed and random operations checked
// against plain 9-bit arithmetic, plus handshake, latency and reset behaviour.
module tb_nibble_serial_adder_8_bit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;

    int vectors;
    int miscompares;

    nibble_serial_adder_8_bit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: accept, latency, optional stall with an ignored
    // in_valid pulse, then result handshake and return to idle.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input int stall, input string tag);
        logic [8:0] expSum;
        int n;
        expSum = {1'b0, a} + {1'b0, b} + {8'b0, c};
        @(negedge clk);
        x = a; y = b; cin = c; in_valid = 1'b1; out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " accept-ready"}, 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0; x = 8'hFF; y = ~b; cin = ~c;
        checkOutput({tag, " busy-not-ready"}, 16'(in_ready), 16'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 16'(n), 16'd2);
        checkOutput({tag, " sum"}, 16'(sum), 16'(expSum[7:0]));
        checkOutput({tag, " cout"}, 16'(cout), 16'(expSum[8]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (s == 1) begin
                in_valid = 1'b1; x = 8'hAA;
            end else begin
                in_valid = 1'b0;
            end
            checkOutput({tag, " held"}, 16'({out_valid, cout, sum}), 16'({1'b1, expSum}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, " released"}, 16'({out_valid, cout, sum}), 16'd0);
        checkOutput({tag, " idle-ready"}, 16'(in_ready), 16'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [8:0] results[$];
        int acceptAt[$];
        logic switchNext;
        logic dropNext;
        logic sawValid;
        logic [8:0] r0;
        logic [8:0] r1;
        int gap;

        vectors = 0; miscompares = 0;
        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset ready", 16'(in_ready), 16'd0);
        checkOutput("reset outputs", 16'({out_valid, cout, sum}), 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset ready", 16'(in_ready), 16'd1);

        // Abort an operation with reset while it is still computing.
        @(negedge clk);
        x = 8'h12; y = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid-calc reset ready", 16'(in_ready), 16'd0);
        checkOutput("mid-calc reset outputs", 16'({out_valid, cout, sum}), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid-calc release ready", 16'(in_ready), 16'd1);
        sawValid = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        out_ready = 1'b0;
        checkOutput("aborted op no result", 16'(sawValid), 16'd0);
        checkOutput("aborted op outputs", 16'({cout, sum}), 16'd0);

        applyStimulus(8'h0F, 8'h01, 1'b0, 0, "nibble carry");
        applyStimulus(8'hFF, 8'h00, 1'b1, 0, "all-ones plus cin");
        applyStimulus(8'h80, 8'h80, 1'b0, 0, "msb overflow");
        applyStimulus(8'h3C, 8'h5A, 1'b1, 5, "backpressure");
        applyStimulus(8'h10, 8'h10, 1'b0, 0, "operand change");

        // Back-to-back with in_valid held high across two operations.
        @(negedge clk);
        x = 8'h01; y = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        switchNext = 1'b0; dropNext = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid) results.push_back({cout, sum});
            if (dropNext) begin
                in_valid = 1'b0; dropNext = 1'b0;
            end
            if (switchNext) begin
                x = 8'hF0; y = 8'h20; cin = 1'b1; switchNext = 1'b0;
            end
            if (in_ready && in_valid) begin
                acceptAt.push_back(i);
                if (acceptAt.size() == 1) switchNext = 1'b1;
                else dropNext = 1'b1;
            end
        end
        out_ready = 1'b0;
        r0  = (results.size() > 0) ? results[0] : 9'h1FF;
        r1  = (results.size() > 1) ? results[1] : 9'h1FF;
        gap = (acceptAt.size() > 1) ? acceptAt[1] - acceptAt[0] : -1;
        checkOutput("b2b result count", 16'(results.size()), 16'd2);
        checkOutput("b2b first result", 16'(r0), 16'h003);
        checkOutput("b2b second result", 16'(r1), 16'h111);
        checkOutput("b2b accept spacing", 16'(gap), 16'd4);

        for (int k = 0; k < 20; k++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
